// File: rtl/spi_flash_cmd_frontend.sv
// UART byte-stream parser that frames ID/program/read/erase commands for an SPI-flash engine.
// Program payload is buffered in a FIFO. Optional inter-byte frame timeout: define FRAME_TIMEOUT_EN.
module spi_flash_cmd_frontend #(
  parameter  int ADDR_BYTES  = 3,
  parameter  int MAX_BURST   = 16,
  parameter  int TIMEOUT_CYC = 50000,
  localparam int LEN_W       = $clog2(MAX_BURST + 1),
  localparam int ADDR_W      = 8 * ADDR_BYTES
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [3:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  output logic [7:0]        wr_data,
  output logic              wr_valid,
  input  logic              wr_pop,
  input  logic              eng_done,
  output logic              busy,
  output logic              err_pulse,
  output logic [1:0]        err_code
);

  localparam int PTR_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [3:0] OP_ID    = 4'b0001;
  localparam logic [3:0] OP_PROG  = 4'b0010;
  localparam logic [3:0] OP_READ  = 4'b0100;
  localparam logic [3:0] OP_ERASE = 4'b1000;

  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_LENGTH  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_ISSUE, S_WAIT} state_t;

  state_t           state;
  logic [2:0]       addr_cnt;
  logic [LEN_W-1:0] data_cnt;

  logic [7:0]       fifo_mem [MAX_BURST];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LEN_W-1:0] fifo_cnt;

  logic byte_acc, push, pop, flush, len_bad, in_frame, timeout_hit;

  assign byte_acc = rx_valid && rx_ready;
  assign in_frame = (state == S_ADDR) || (state == S_LEN) || (state == S_DATA);
  assign push     = (state == S_DATA) && byte_acc;
  assign pop      = wr_pop && wr_valid;
  assign len_bad  = (rx_data == 8'h00) || ({1'b0, rx_data} > 9'(MAX_BURST));
  assign flush    = ((state == S_WAIT) && eng_done) ||
                    ((state == S_LEN) && byte_acc && len_bad) || timeout_hit;

  assign wr_valid = (fifo_cnt != '0);
  assign wr_data  = wr_valid ? fifo_mem[rd_ptr] : 8'h00;

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt;

  // Counts idle cycles between accepted bytes while a frame is open.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                                   to_cnt <= '0;
    else if (!in_frame || byte_acc || timeout_hit) to_cnt <= '0;
    else                                       to_cnt <= to_cnt + TO_W'(1);
  end

  assign timeout_hit = in_frame && !byte_acc && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: payload storage carries no reset; wr_data is masked to zero while empty,
  // so stale contents are never observable and the array maps onto plain RAM.
  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr] <= rx_data;
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch below sees the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      addr_cnt  <= '0;
      data_cnt  <= '0;
      rx_ready  <= 1'b1;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      busy      <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
    end else begin
      err_pulse <= 1'b0;

      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      fifo_cnt <= fifo_cnt + LEN_W'(1);
        else if (pop && !push) fifo_cnt <= fifo_cnt - LEN_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (byte_acc) begin
            case (rx_data)
              8'h57, 8'h52, 8'h53: begin
                cmd_op   <= (rx_data == 8'h57) ? OP_PROG :
                            (rx_data == 8'h52) ? OP_READ : OP_ERASE;
                cmd_addr <= '0;
                cmd_len  <= '0;
                addr_cnt <= '0;
                err_code <= '0;
                state    <= S_ADDR;
              end
              8'h49: begin
                cmd_op    <= OP_ID;
                cmd_addr  <= '0;
                cmd_len   <= '0;
                err_code  <= '0;
                cmd_valid <= 1'b1;
                rx_ready  <= 1'b0;
                busy      <= 1'b1;
                state     <= S_ISSUE;
              end
              default: begin
                err_pulse <= 1'b1;
                err_code  <= ERR_OPCODE;
              end
            endcase
          end
        end

        S_ADDR: begin
          if (byte_acc) begin
            cmd_addr <= (cmd_addr << 8) | ADDR_W'(rx_data);
            addr_cnt <= addr_cnt + 3'd1;
            if (addr_cnt == 3'(ADDR_BYTES - 1)) begin
              if (cmd_op == OP_ERASE) begin
                cmd_valid <= 1'b1;
                rx_ready  <= 1'b0;
                busy      <= 1'b1;
                state     <= S_ISSUE;
              end else begin
                state <= S_LEN;
              end
            end
          end
        end

        S_LEN: begin
          if (byte_acc) begin
            if (len_bad) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_LENGTH;
              state     <= S_IDLE;
            end else begin
              cmd_len  <= LEN_W'(rx_data);
              data_cnt <= '0;
              if (cmd_op == OP_READ) begin
                cmd_valid <= 1'b1;
                rx_ready  <= 1'b0;
                busy      <= 1'b1;
                state     <= S_ISSUE;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (byte_acc) begin
            data_cnt <= data_cnt + LEN_W'(1);
            if (data_cnt + LEN_W'(1) == cmd_len) begin
              cmd_valid <= 1'b1;
              rx_ready  <= 1'b0;
              busy      <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (eng_done) begin
            rx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Timeout only fires in a frame state on a cycle with no accepted byte.
      if (timeout_hit) begin
        err_pulse <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state     <= S_IDLE;
      end
    end
  end

endmodule
